// File: rtl/mul_operand_sequencer.sv
// Feeds operand pairs to the repeated-addition multiplier (start, A, B on one bus) and returns its product; 4+N cycles accept-to-result.
// One job in flight: in_ready only in IDLE, result held while out_ready=0. `MUL_ZERO_BYPASS_EN answers zero operands without the multiplier.
module mul_operand_sequencer #(
  parameter int W       = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_product,
  output logic         out_timeout,
  output logic         busy,
  output logic         mul_start,
  output logic [W-1:0] mul_data,
  output logic         mul_clr,
  input  logic         mul_done,
  input  logic [W-1:0] mul_product
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] TERM = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    LOAD_A,
    LOAD_B,
    WAIT,
    HOLD,
    CLEAR
  } state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  a_q, b_q;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  prod_q;
  logic          to_q;

`ifdef MUL_ZERO_BYPASS_EN
  logic byp_q;
  logic zero_in;
  assign zero_in = (in_a == '0) || (in_b == '0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      cnt_q  <= '0;
      prod_q <= '0;
      to_q   <= 1'b0;
`ifdef MUL_ZERO_BYPASS_EN
      byp_q  <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q <= in_a;
            b_q <= in_b;
`ifdef MUL_ZERO_BYPASS_EN
            byp_q <= zero_in;
            if (zero_in) begin
              prod_q <= '0;
              to_q   <= 1'b0;
            end
`endif
          end
        end
        LOAD_B: cnt_q <= '0;
        WAIT: begin
          cnt_q <= cnt_q + CW'(1);
          // done takes priority over a coincident terminal count
          if (mul_done) begin
            prod_q <= mul_product;
            to_q   <= 1'b0;
          end else if (cnt_q == TERM) begin
            prod_q <= '0;
            to_q   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    mul_start = 1'b0;
    mul_data  = '0;
    mul_clr   = rst;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
`ifdef MUL_ZERO_BYPASS_EN
          state_nxt = zero_in ? HOLD : START;
`else
          state_nxt = START;
`endif
        end
      end
      START:  state_nxt = LOAD_A;
      LOAD_A: state_nxt = LOAD_B;
      LOAD_B: state_nxt = WAIT;
      WAIT: begin
        if (mul_done || (cnt_q == TERM)) state_nxt = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
`ifdef MUL_ZERO_BYPASS_EN
          state_nxt = byp_q ? IDLE : CLEAR;
`else
          state_nxt = CLEAR;
`endif
        end
      end
      CLEAR:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // reset forces every handshake and bus output quiet, whatever state is held
    if (!rst) begin
      case (state)
        IDLE:    in_ready  = 1'b1;
        START:   mul_start = 1'b1;
        LOAD_A:  mul_data  = a_q;
        LOAD_B:  mul_data  = b_q;
        HOLD:    out_valid = 1'b1;
        CLEAR:   mul_clr   = 1'b1;
        default: ;
      endcase
    end
  end

  assign busy        = (state != IDLE);
  assign out_product = rst ? '0 : prod_q;
  assign out_timeout = rst ? 1'b0 : to_q;

endmodule

// File: doc/mul_operand_sequencer.md
Name: mul_operand_sequencer

Overview:
- Upstream feeder for the repeated-addition multiplier: accepts an operand pair over a valid/ready handshake and drives the multiplier's single shared data bus and start line in the cycle order its controller expects.
- Waits for the multiplier's done, captures the product, and presents it downstream over a valid/ready handshake.
- Issues a clear pulse to return the multiplier to idle between jobs.
- Guards against a hung multiplier with a cycle timeout.

Parameters:
- W, 16, operand, bus and product width.
- TIMEOUT, 1024, maximum WAIT cycles before aborting a job; must be at least 2.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  sequencer can accept a pair.
- in_a  in  W  multiplicand.
- in_b  in  W  multiplier (repeat count).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_product  out  W  captured product, low W bits.
- out_timeout  out  1  result is an aborted job; qualified by out_valid.
- busy  out  1  high in any state other than IDLE.
- mul_start  out  1  start request to the multiplier.
- mul_data  out  W  multiplier shared data bus.
- mul_clr  out  1  multiplier return-to-idle pulse.
- mul_done  in  1  multiplier done (sticky until mul_clr).
- mul_product  in  W  multiplier product register.

Behaviour:
- Reset state:
  - While rst is high: state=IDLE, timeout counter=0, out_valid=0, out_timeout=0, out_product=0, mul_start=0, mul_data=0, in_ready=0.
  - mul_clr=1 throughout reset. This applies to a reset mid-job in any state.
  - First cycle after rst deasserts: IDLE with in_ready=1.
- FSM states: IDLE, START, LOAD_A, LOAD_B, WAIT, HOLD, CLEAR.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, latch in_a and in_b into internal registers and go to START.
- START: mul_start=1, mul_data=0, then go to LOAD_A.
- LOAD_A: mul_data=latched A, mul_start=0, then go to LOAD_B.
- LOAD_B: mul_data=latched B, then go to WAIT. Clear the timeout counter on entry.
- WAIT:
  - mul_data=0 and the counter increments each cycle.
  - If mul_done=1, register mul_product into out_product, set out_timeout=0 and go to HOLD.
  - Otherwise, when the counter reaches TIMEOUT-1, set out_product=0 and out_timeout=1 and go to HOLD.
  - If mul_done and the terminal count occur in the same cycle, done wins (out_timeout=0).
- HOLD:
  - out_valid=1; out_product and out_timeout stay stable.
  - Hold indefinitely while out_ready=0.
  - On out_ready=1, clear out_valid at that edge and go to CLEAR.
- CLEAR: mul_clr=1 for exactly one cycle, then go to IDLE.
- in_ready is 0 in every state except IDLE; only one job is in flight at a time. A new pair is accepted no earlier than the cycle after CLEAR.
- Latency: from the accept edge to out_valid is 4 + N cycles, where N is the number of WAIT cycles until mul_done is seen (N≥1).
- Back-to-back throughput: one job per 6 + N cycles when out_ready is held at 1.
- Width rule: products are truncated to W bits as produced by the multiplier; the sequencer performs no arithmetic except in the bypass option.

Optional Feature:
- Macro: MUL_ZERO_BYPASS_EN.
- Defined:
  - If latched A==0 or B==0 at accept, skip START through WAIT and CLEAR.
  - Go directly to HOLD the cycle after accept with out_product=0 and out_timeout=0; mul_start, mul_data and mul_clr stay 0.
  - After the handshake, return to IDLE.
  - This avoids the multiplier's B=0 counter wrap.
- Undefined: zero operands follow the normal sequence, and a B=0 job completes only via timeout.

Test Plan:
- A=17, B=5; the multiplier model raises done 5 WAIT cycles after LOAD_B with product 85 -> mul_start high 1 cycle, mul_data shows 17 then 5 on consecutive cycles, out_valid at accept+9, out_product=85, out_timeout=0, mul_clr 1 cycle after the handshake.
- The same job with out_ready held 0 for 7 cycles -> out_valid and out_product=85 stable for all 7 cycles; in_ready=0; CLEAR occurs only after out_ready rises.
- TIMEOUT=8 with mul_done tied 0 -> out_valid 8 WAIT cycles after LOAD_B with out_timeout=1 and out_product=0, followed by a mul_clr pulse.
- Two back-to-back pairs (3,4) and (6,7) with in_valid continuously high -> second accept in the cycle after CLEAR; outputs 12 then 42 in order.
- rst asserted for one cycle mid-WAIT -> next cycle IDLE, out_valid=0, mul_clr=1 during reset; a fresh pair (2,9) then completes with product 18.
- With MUL_ZERO_BYPASS_EN, pair (0,123) -> out_valid the cycle after accept, product 0, mul_start never asserted. Without the macro -> normal sequence is issued.
